// File: rtl/kernel_cc_fifo_unpack_w64_w32.sv
// Drains a programmed count of 2*OUT_WIDTH-bit words from an upstream FIFO and
// re-emits each as two OUT_WIDTH-bit beats (low half first) into a downstream FIFO.
module kernel_cc_fifo_unpack_w64_w32 #(
    parameter int OUT_WIDTH = 32,
    parameter int CNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ap_start,
    output logic                   ap_idle,
    output logic                   ap_done,
    input  logic [CNT_WIDTH-1:0]   num_words,
    input  logic                   in_empty_n,
    output logic                   in_read,
    input  logic [2*OUT_WIDTH-1:0] in_dout,
    input  logic                   out_full_n,
    output logic                   out_write,
    output logic [OUT_WIDTH-1:0]   out_din
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   len_q, len_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [2*OUT_WIDTH-1:0] hold_q, hold_d;
    logic                   hold_valid_q, hold_valid_d;
    logic                   half_q, half_d;
    logic                   done_q, done_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            cnt_q        <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            half_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            half_q       <= half_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        half_d       = half_q;
        done_d       = 1'b0;
        in_read      = 1'b0;
        out_write    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    len_d   = num_words;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // A new word may be popped only once the high half leaves this cycle.
                in_read   = (cnt_q < len_q) && in_empty_n &&
                            (!hold_valid_q || (half_q && out_full_n));
                out_write = hold_valid_q && out_full_n;
                if (out_write) begin
                    if (!half_q) begin
                        half_d = 1'b1;
                    end else begin
                        half_d       = 1'b0;
                        hold_valid_d = 1'b0;
                    end
                end
                if (in_read) begin
                    hold_d       = in_dout;
                    hold_valid_d = 1'b1;
                    half_d       = 1'b0;
                    cnt_d        = cnt_q + CNT_WIDTH'(1);
                end
                // Judged on next-state values so done lands the cycle after the last beat.
                if ((cnt_d == len_q) && !hold_valid_d) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ap_idle = (state_q == S_IDLE);
    assign ap_done = done_q;
    assign out_din = half_q ? hold_q[2*OUT_WIDTH-1:OUT_WIDTH] : hold_q[OUT_WIDTH-1:0];

endmodule

// File: doc/kernel_cc_fifo_unpack_w64_w32.md
Name: kernel_cc_fifo_unpack_w64_w32

Overview:
- Reader-side consumer for the kernel's 64-bit ap_fifo channels. Drains a programmed number of 64-bit words from an upstream FIFO read port (empty_n/read/dout).
- Splits each word into two 32-bit beats, low half first, and pushes them into a downstream FIFO write port (full_n/write/din).
- Started and completed via an ap_start/ap_done/ap_idle control handshake.
- Sits between an edge/vertex stream FIFO and 32-bit vertex-ID processing stages.

Parameters:
- OUT_WIDTH, 32, downstream beat width; upstream word width is fixed at 2*OUT_WIDTH.
- CNT_WIDTH, 32, width of the word-count input and internal counter.

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- ap_start  input  1  start request, sampled only while idle
- ap_idle  output  1  high when no transfer is in progress
- ap_done  output  1  one-cycle pulse when the transfer completes
- num_words  input  CNT_WIDTH  number of 64-bit words to consume; latched on accepted start
- in_empty_n  input  1  upstream FIFO has data
- in_read  output  1  pop upstream FIFO this cycle
- in_dout  input  2*OUT_WIDTH  upstream head word, valid whenever in_empty_n=1
- out_full_n  input  1  downstream FIFO has space
- out_write  output  1  push downstream FIFO this cycle
- out_din  output  OUT_WIDTH  beat being pushed

Behaviour:
- Reset (synchronous, active-high) clears all state:
  - state=IDLE; ap_idle=1; ap_done=0; in_read=0; out_write=0.
  - hold register=0; hold_valid=0; half=0; word counter=0.
  - Reset mid-transfer discards the held word and the remaining count. Upstream FIFO contents are not drained.
- States: IDLE, RUN.
- IDLE:
  - ap_idle=1.
  - ap_start=1 latches num_words into len, clears the counter, and moves to RUN next cycle.
- RUN:
  - ap_idle=0.
  - ap_start is ignored while in RUN.
- in_read (combinational) = RUN & (cnt<len) & in_empty_n & (!hold_valid | (half==1 & out_full_n)).
- On in_read:
  - hold <= in_dout; hold_valid <= 1; half <= 0; cnt <= cnt+1.
- out_write (combinational) = RUN & hold_valid & out_full_n.
- out_din = half ? hold[2*OUT_WIDTH-1:OUT_WIDTH] : hold[OUT_WIDTH-1:0]. It holds its value while stalled.
- On out_write:
  - If half==0: half <= 1.
  - If half==1: half <= 0, and hold_valid <= 0 unless an in_read occurs in the same cycle (the refill takes priority and keeps hold_valid=1).
- Completion:
  - When RUN & cnt==len & !hold_valid, the block returns to IDLE and ap_done pulses exactly one cycle, registered.
  - ap_idle=1 in the cycle that ap_done=1.
- num_words=0: ap_done pulses on the second cycle after start. No in_read and no out_write occur.
- Latency and throughput, with start sampled at cycle t and no stalls:
  - First in_read at t+1.
  - Beats written at t+2 .. t+2N+1, one per cycle.
  - ap_done at t+2N+2.
- Backpressure:
  - out_full_n=0 freezes hold, half and cnt; no in_read occurs while the held word is unfinished.
  - in_empty_n=0 with an empty hold produces bubbles only; no beat is lost or duplicated.
- Counter arithmetic is unsigned, CNT_WIDTH bits. len up to 2^CNT_WIDTH-1 must complete without wrap.
- in_read is never asserted when in_empty_n=0. out_write is never asserted when out_full_n=0.

Test Plan:
- Reset, then idle check -> ap_idle=1, ap_done=0, in_read=0, out_write=0 for 10 cycles with the upstream FIFO non-empty.
- num_words=3; upstream holds 0x1111_1111_0000_0000, 0x3333_3333_2222_2222, 0x5555_5555_4444_4444; out_full_n=1 -> out_din sequence 0x00000000, 0x11111111, 0x22222222, 0x33333333, 0x44444444, 0x55555555 on consecutive cycles t+2..t+7; ap_done at t+8 only; the fourth upstream word is not popped.
- Same stream with out_full_n toggling 1,0,0,1,... pseudo-randomly -> identical 6-beat sequence, no duplicates; in_read count = 3; out_write never high when out_full_n=0.
- Upstream empty for 5 cycles between words, num_words=2 -> 4 beats in order; ap_done one cycle after the fourth beat.
- num_words=0 -> no in_read and no out_write; ap_done pulses at t+2; ap_start pulsed again during a later RUN is ignored.
- Reset asserted after 3 beats of a 4-word job -> next cycle ap_idle=1 and in_read=out_write=0; a fresh start with num_words=1 emits the low then high half of the next upstream word.
